// File: rtl/silu_lut_arbiter_pkg.sv
// Shared types and helpers for the SiLU LUT arbiter slice.
package silu_lut_arbiter_pkg;

    localparam int SILU_DATA_WIDTH = 6;
    localparam int SILU_FRAC_WIDTH = 3;

    typedef logic [SILU_DATA_WIDTH-1:0] silu_data_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/silu_lut.sv
// Fixed 6-bit SiLU table: Q2.3 two's complement in, Q2.3 out, round-to-nearest.
module silu_lut
    import silu_lut_arbiter_pkg::*;
(
    input  silu_data_t x,
    output silu_data_t y
);

    always_comb begin
        y = '0;
        case (x) inside
            6'd0:                         y = 6'd0;
            6'd1, 6'd2:                   y = 6'd1;
            6'd3, 6'd4:                   y = 6'd2;
            [6'd5:6'd20]:                 y = x - 6'd2;
            [6'd21:6'd31]:                y = x - 6'd1;
            // negative side: SiLU bottoms out near -0.28, so only -1/-2 LSB survive
            [6'd32:6'd43], 6'd61, 6'd62:  y = 6'd63;
            [6'd44:6'd60]:                y = 6'd62;
            default:                      y = 6'd0;
        endcase
    end

endmodule

// File: rtl/silu_rr_arbiter.sv
// Combinational round-robin grant: first valid lane at or after ptr, wrapping.
module silu_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                gnt_vld,
    output logic [ID_WIDTH-1:0] gnt_idx
);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        // walk offsets farthest-first so the closest valid lane to ptr wins
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (valid[j] && (j == ((int'(ptr) + i) % NUM_REQ))) begin
                    gnt_vld = 1'b1;
                    gnt_idx = ID_WIDTH'(j);
                end
            end
        end
    end

endmodule

// File: rtl/silu_lut_arbiter.sv
// NUM_REQ-way round-robin front end sharing one SiLU LUT, single registered response slot.
// Optional stall counter enabled by SILU_LUT_ARBITER_STALL_CNT_EN.
module silu_lut_arbiter
    import silu_lut_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = SILU_DATA_WIDTH,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic                          rsp_valid,
    input  logic                          rsp_ready
`ifdef SILU_LUT_ARBITER_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cycles
`endif
);

    logic [ID_WIDTH-1:0] rr_ptr;
    logic                gnt_vld;
    logic [ID_WIDTH-1:0] gnt_idx;
    logic                load_en;
    silu_data_t          lane_data;
    silu_data_t          lut_out;

    assign load_en = !rsp_valid || rsp_ready;

    silu_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .valid   (req_valid),
        .ptr     (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // req_ready depends only on valid/ptr/slot state, never on req_data
    always_comb begin
        req_ready = '0;
        lane_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == ID_WIDTH'(k)) begin
                req_ready[k] = load_en && gnt_vld;
                lane_data    = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    silu_lut u_lut (
        .x (lane_data),
        .y (lut_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            if (gnt_vld) begin
                rsp_valid <= 1'b1;
                rsp_data  <= lut_out;
                rsp_id    <= gnt_idx;
                rr_ptr    <= ID_WIDTH'(rr_next(int'(gnt_idx), NUM_REQ));
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef SILU_LUT_ARBITER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (rsp_valid && !rsp_ready && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_silu_lut_arbiter.sv
// Self-checking bench: cycle model + response scoreboard, LUT key-point table, corner sequences.
module tb_silu_lut_arbiter;

    localparam int N  = 4;
    localparam int DW = 6;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            rsp_valid;
    logic            rsp_ready;
`ifdef SILU_LUT_ARBITER_STALL_CNT_EN
    logic [31:0]     stall_cycles;
`endif

    always #5 clk = ~clk;

    silu_lut_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready)
`ifdef SILU_LUT_ARBITER_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    typedef struct packed {
        logic [5:0] d;
        logic [1:0] id;
    } rsp_t;

    typedef struct {
        logic [5:0] din;
        logic [5:0] dout;
    } vec_t;

    rsp_t sb[$];
    vec_t tbl[11];
    int   n_vec = 0;
    int   n_bad = 0;
    logic m_valid;
    int   m_ptr;

    // reference SiLU computed in real arithmetic, rounded to nearest Q2.3
    function automatic logic [5:0] silu_ref(input logic [5:0] c);
        int  v;
        int  r;
        real x;
        real s;
        v = int'($signed(c));
        x = real'(v) / 8.0;
        s = x / (1.0 + $exp(-x));
        r = int'($floor(s * 8.0 + 0.5));
        return r[5:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock: check DUT against model at negedge, then advance model across posedge
    task automatic step();
        logic       ld;
        int         g;
        logic [N-1:0] exp_rdy;
        logic [5:0] lane;
        @(negedge clk);
        ld = !m_valid || rsp_ready;
        g  = -1;
        for (int i = N - 1; i >= 0; i--) begin
            int k;
            k = (m_ptr + i) % N;
            if (req_valid[k]) g = k;
        end
        exp_rdy = '0;
        if (ld && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                chk("rsp_data", 32'(rsp_data), 32'(sb[0].d));
                chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
        if (ld) begin
            if (g >= 0) begin
                lane = req_data[g*DW +: DW];
                sb.push_back('{d: silu_ref(lane), id: 2'(g)});
                m_valid = 1'b1;
                m_ptr   = (g == N - 1) ? 0 : g + 1;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{6'd0,  6'd0};
        tbl[1]  = '{6'd8,  6'd6};
        tbl[2]  = '{6'd31, 6'd30};
        tbl[3]  = '{6'd32, 6'd63};
        tbl[4]  = '{6'd44, 6'd62};
        tbl[5]  = '{6'd52, 6'd62};
        tbl[6]  = '{6'd60, 6'd62};
        tbl[7]  = '{6'd61, 6'd63};
        tbl[8]  = '{6'd62, 6'd63};
        tbl[9]  = '{6'd63, 6'd0};
        tbl[10] = '{6'd48, 6'd62};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        m_valid   = 1'b0;
        m_ptr     = 0;
        #12;
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_data", 32'(rsp_data), 32'd0);
        chk("reset_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // all lanes streaming: strict 0,1,2,3 rotation at full rate
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_data = 24'($urandom);
            step();
            chk("rr_seq_id", 32'(rsp_id), 32'(i % 4));
            chk("rr_seq_valid", 32'(rsp_valid), 32'd1);
        end
        req_valid = '0;
        step();

        // LUT key points through lane 0
        for (int i = 0; i < 11; i++) begin
            req_valid = 4'b0001;
            req_data  = {18'd0, tbl[i].din};
            step();
            chk($sformatf("lut_%0d", tbl[i].din), 32'(rsp_data), 32'(tbl[i].dout));
        end
        req_valid = '0;
        step();

        // pointer at 2 with lanes 1 and 3 pending: 3 first, then wrap to 1
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1010;
        step();
        chk("wrap_first", 32'(rsp_id), 32'd3);
        step();
        chk("wrap_second", 32'(rsp_id), 32'd1);
        req_valid = '0;
        step();

        // back-pressure: slot holds SiLU(-0.125)=0, no lane is granted
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_data  = {18'd0, 6'b111111};
        step();
        req_valid = 4'b0101;
        req_data  = {6'd0, 6'b100000, 6'd0, 6'b111111};
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_data", 32'(rsp_data), 32'd0);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        step();
        chk("release_id", 32'(rsp_id), 32'd2);
        chk("release_data", 32'(rsp_data), 32'b111111);
        chk("release_valid", 32'(rsp_valid), 32'd1);

        // back-to-back burst on lane 1
        req_valid = 4'b0010;
        req_data  = {12'd0, 6'b100000, 6'd0};
        step();
        chk("burst0", 32'(rsp_data), 32'b111111);
        req_data  = {12'd0, 6'b110000, 6'd0};
        step();
        chk("burst1", 32'(rsp_data), 32'b111110);
        req_data  = {12'd0, 6'b111101, 6'd0};
        step();
        chk("burst2", 32'(rsp_data), 32'b111111);
        req_valid = '0;
        step();

        // async reset while a response is held
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        req_data  = {6'd8, 18'd0};
        step();
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_data", 32'(rsp_data), 32'd0);
        chk("async_rst_id", 32'(rsp_id), 32'd0);
        sb.delete();
        m_valid   = 1'b0;
        m_ptr     = 0;
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_lane0", 32'(rsp_id), 32'd0);

        // random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom);
            req_data  = 24'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/silu_lut_arbiter.md
Name: silu_lut_arbiter

Overview:
- Shares one combinational 6-bit SiLU lookup table between NUM_REQ streaming requesters, using valid/ready handshakes and round-robin arbitration.
- Each granted sample goes through the LUT and is registered on a single response stream. The response carries the requester index as a tag.
- Sits between per-lane activation producers and the downstream demux/accumulator in the quantised activation path.

Parameters:
- NUM_REQ, 4, number of requester ports (2..16; need not be a power of two)
- DATA_WIDTH, 6, sample width; fixed-point, 3 fractional bits, two's complement. Must stay 6 to match the LUT.
- ID_WIDTH, $clog2(NUM_REQ) (minimum 1), width of the response tag

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_data  in  NUM_REQ*DATA_WIDTH  flattened samples; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_valid  in  NUM_REQ  per-lane valid
- req_ready  out  NUM_REQ  per-lane ready; one-hot or zero
- rsp_data  out  DATA_WIDTH  SiLU(sample)
- rsp_id  out  ID_WIDTH  index of the lane that produced rsp_data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0. Counter (if enabled) = 0.
- Reset mid-operation drops any held response; it does not reappear after reset.
- Pipeline slot:
  - load_en = !rsp_valid || rsp_ready.
  - The output register accepts a new sample when load_en=1, giving full throughput of 1 sample/cycle under continuous rsp_ready.
- Arbitration:
  - Grant g = first k with req_valid[k]=1, searching k = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - No valid lane means no grant.
  - req_ready[g] = load_en; all other req_ready = 0.
  - req_ready may depend combinationally on req_valid and rsp_ready; there is no comb path from req_data.
- On handshake (req_valid[g] && req_ready[g]):
  - rsp_data <= LUT(req_data lane g); rsp_id <= g; rsp_valid <= 1.
  - rr_ptr <= (g == NUM_REQ-1) ? 0 : g+1.
  - Latency: exactly 1 cycle from input handshake to rsp_valid.
- No grant while load_en=1: rsp_valid <= 0 and rr_ptr is unchanged.
- rsp_valid=1 && rsp_ready=0: rsp_data, rsp_id and rsp_valid hold stable; all req_ready=0.
- Simultaneous response accept and new grant in the same cycle: new sample replaces the old one; no bubble.
- LUT contents are fixed (6-bit in, 6-bit out). Key points:
  - 0 -> 0
  - 8 (1.0) -> 6 (0.75)
  - 31 -> 30
  - 32 (-4.0) -> 63
  - 44..60 -> 62
  - 61, 62 -> 63
  - 63 (-0.125) -> 0
- No starvation: a lane holding req_valid is granted within NUM_REQ handshakes.

Optional Feature:
- Macro: SILU_LUT_ARBITER_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cycles (out, 32 bits).
  - Increments each cycle rsp_valid && !rsp_ready; saturates at 2^32-1; reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package silu_lut_arbiter_pkg:
  - SILU_DATA_WIDTH=6, SILU_FRAC_WIDTH=3
  - typedef silu_data_t (logic [5:0])
  - function rr_next(ptr, n) for the wrap-around increment
- Sub-modules:
  - Existing silu_lut instantiated unchanged as the datapath.
  - One natural new sub-module: silu_rr_arbiter (pure combinational priority-from-pointer grant; pointer register stays in the top).

Test Plan:
- Lane 0 only, req_data=6'b001000, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=6'b000110, rsp_id=0.
- All 4 lanes valid continuously, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3; one response per cycle.
- Lanes 1 and 3 valid, rr_ptr=2 -> lane 3 granted first, then lane 1 (wrap past 3 to 0).
- Hold rsp_ready=0 with response 6'b111111 in the slot -> rsp_data=6'b000000 stable for 5 cycles; req_ready=0 throughout.
- Release rsp_ready -> same-cycle grant; no bubble.
- Inputs 6'b100000, 6'b110000, 6'b111101 -> rsp_data 6'b111111, 6'b111110, 6'b111111.
- Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately (async). After release, first grant is from lane 0.
